// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types, byte-enable encodings and lane helpers for the memory-stage LSU.
package arm_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} lsu_state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Bit distance from lane 0 to the lowest enabled lane.
    function automatic logic [4:0] lane_shift(input logic [3:0] be);
        return be[0] ? 5'd0 : be[1] ? 5'd8 : be[2] ? 5'd16 : be[3] ? 5'd24 : 5'd0;
    endfunction

    function automatic logic be_legal(input logic [3:0] be);
        return be inside {BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
    endfunction

endpackage

// File: rtl/lane_align.sv
// lane_align: masks disabled byte lanes and right-justifies the loaded bytes, zero-extended.
module lane_align
    import arm_mem_pkg::*;
(
    input  logic [3:0]  be,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] mask;

    assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign data = (rdata & mask) >> lane_shift(be);

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: single-outstanding data-bus load/store unit with upstream stall and MEM/WB register.
// Bus request fields come straight from the EX/MEM outputs, which upstream holds while stalled.
module mem_stage_lsu
    import arm_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  WA3M,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        branchLinkM,
    input  logic [3:0]  beM,
    input  logic [31:0] PCPlus4M,
    output logic        dbus_valid,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ready,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        stallM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        branchLinkW,
    output logic [31:0] PCPlus4W
);

    lsu_state_t  state, state_nx;
    logic        memop, is_load, is_store, accepted, done, stale_rsp;
    logic [31:0] load_data;

    assign memop    = MemtoRegM | MemWriteM;
    assign is_load  = MemtoRegM & ~MemWriteM;
    assign is_store = MemWriteM;

    assign dbus_addr  = {ALUResultM[31:2], 2'b00};
    assign dbus_we    = is_store;
    assign dbus_be    = beM;
    assign dbus_wdata = WriteDataM;
    assign accepted   = dbus_valid & dbus_ready;
    assign stallM     = reset_n & ~done;

    lane_align u_lane_align (
        .be    (beM),
        .rdata (dbus_rdata),
        .data  (load_data)
    );

    always_comb begin
        dbus_valid = reset_n & (((state == IDLE) & memop) | (state == REQ));
        done       = ((state == IDLE) & ~memop) | (dbus_valid & dbus_ready & is_store)
                   | ((state == WAIT_RD) & dbus_rvalid);
        state_nx   = state;
        if (state == WAIT_RD)
            state_nx = dbus_rvalid ? IDLE : WAIT_RD;
        else if (dbus_valid & dbus_ready)
            state_nx = is_load ? WAIT_RD : IDLE;
        else if (dbus_valid)
            state_nx = REQ;
    end

    // A response to a request abandoned by reset may still arrive; it is tolerated until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stale_rsp <= 1'b1;
        end else begin
            state <= state_nx;
            if (accepted)
                stale_rsp <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ReadDataW   <= '0;
            ALUOutW     <= '0;
            WA3W        <= '0;
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            branchLinkW <= 1'b0;
            PCPlus4W    <= '0;
        end else if (done) begin
            ReadDataW   <= is_load ? load_data : '0;
            ALUOutW     <= ALUResultM;
            WA3W        <= WA3M;
            RegWriteW   <= RegWriteM;
            MemtoRegW   <= MemtoRegM;
            branchLinkW <= branchLinkM;
            PCPlus4W    <= PCPlus4M;
        end else begin
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            branchLinkW <= 1'b0;
        end
    end

    a_ld_st_excl: assert property (@(posedge clk) disable iff (!reset_n) !(MemtoRegM && MemWriteM))
        else $error("mem_stage_lsu: MemtoRegM and MemWriteM both set");
    a_be_legal: assert property (@(posedge clk) disable iff (!reset_n) dbus_valid |-> be_legal(beM))
        else $error("mem_stage_lsu: illegal byte enable %b", beM);
    a_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
        dbus_rvalid |-> (state == WAIT_RD || stale_rsp))
        else $error("mem_stage_lsu: dbus_rvalid outside WAIT_RD");
    a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
        dbus_valid && !dbus_ready |=> dbus_valid && $stable({dbus_addr, dbus_we, dbus_be, dbus_wdata}))
        else $error("mem_stage_lsu: request dropped or changed before accept");

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu against a transaction-level model.
module tb_mem_stage_lsu;

    localparam int NOP = 0, LD = 1, ST = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dbus_rdata;
    logic [3:0]  WA3M, beM;
    logic        RegWriteM, MemtoRegM, MemWriteM, branchLinkM, dbus_ready, dbus_rvalid;
    logic        dbus_valid, dbus_we, stallM, RegWriteW, MemtoRegW, branchLinkW;
    logic [31:0] dbus_addr, dbus_wdata, ReadDataW, ALUOutW, PCPlus4W;
    logic [3:0]  dbus_be, WA3W;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .reset_n(reset_n),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .branchLinkM(branchLinkM), .beM(beM), .PCPlus4M(PCPlus4M),
        .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_we(dbus_we),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .stallM(stallM),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .branchLinkW(branchLinkW), .PCPlus4W(PCPlus4W)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Enabled bytes gathered in lane order and packed from bit 0 upward.
    function automatic logic [31:0] ref_load(input logic [3:0] be, input logic [31:0] w);
        logic [31:0] r;
        int pos;
        r = '0;
        pos = 0;
        for (int i = 0; i < 4; i++)
            if (be[i]) begin
                r = r | (((w >> (8 * i)) & 32'hFF) << (8 * pos));
                pos++;
            end
        return r;
    endfunction

    task automatic set_nop();
        ALUResultM = '0; WriteDataM = '0; WA3M = '0; RegWriteM = 0; MemtoRegM = 0;
        MemWriteM = 0; branchLinkM = 0; beM = '0; PCPlus4M = '0;
    endtask

    // Presents one op just after a rising edge, plays the bus, and checks stalls and the WB capture.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [3:0] wa3, input logic rw, input logic bl,
                         input logic [31:0] pc4, input logic [31:0] rdata, input int n_wait, input int k);
        int cyc, acc, stalls, exp_stalls;
        logic st;
        ALUResultM = addr; WriteDataM = wdata; beM = be; WA3M = wa3; RegWriteM = rw;
        branchLinkM = bl; PCPlus4M = pc4; MemtoRegM = (kind == LD); MemWriteM = (kind == ST);
        dbus_rdata = rdata;
        cyc = 0; acc = -1; stalls = 0;
        exp_stalls = (kind == NOP) ? 0 : (kind == ST) ? n_wait : n_wait + k;
        forever begin
            dbus_ready = (cyc >= n_wait);
            dbus_rvalid = (kind == LD && acc >= 0 && cyc == acc + k);
            @(negedge clk);
            chk("dbus_valid", 32'(dbus_valid), 32'(kind != NOP && acc < 0));
            if (dbus_valid) begin
                chk("dbus_addr", dbus_addr, addr & ~32'h3);
                chk("dbus_we", 32'(dbus_we), 32'(kind == ST));
                chk("dbus_be", 32'(dbus_be), 32'(be));
                chk("dbus_wdata", dbus_wdata, wdata);
                if (dbus_ready) acc = cyc;
            end
            st = stallM;
            @(posedge clk);
            #1;
            if (!st) break;
            stalls++;
            cyc++;
            chk("bubble_ctl", {29'd0, RegWriteW, MemtoRegW, branchLinkW}, 32'd0);
            if (stalls > 40) begin
                chk("stall_timeout", 32'(stalls), 32'(exp_stalls));
                break;
            end
        end
        dbus_ready = 0;
        dbus_rvalid = 0;
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("ALUOutW", ALUOutW, addr);
        chk("WA3W", 32'(WA3W), 32'(wa3));
        chk("RegWriteW", 32'(RegWriteW), 32'(rw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(kind == LD));
        chk("branchLinkW", 32'(branchLinkW), 32'(bl));
        chk("PCPlus4W", PCPlus4W, pc4);
        chk("ReadDataW", ReadDataW, (kind == LD) ? ref_load(be, rdata) : 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind;
        logic rw;
        set_nop();
        dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ALUOutW", ALUOutW, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        chk("rst_PCPlus4W", PCPlus4W, 32'd0);
        chk("rst_ctl", {25'd0, WA3W, RegWriteW, MemtoRegW, branchLinkW}, 32'd0);
        chk("rst_stallM", 32'(stallM), 32'd0);
        chk("rst_dbus_valid", 32'(dbus_valid), 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        do_op(NOP, 32'h1234, 32'h0, 4'b0000, 4'd3, 1'b1, 1'b0, 32'h8, 32'h0, 0, 1);
        chk("add_ALUOutW", ALUOutW, 32'h1234);
        do_op(ST, 32'h1003, 32'hCAFEF00D, 4'b1111, 4'd0, 1'b0, 1'b0, 32'hC, 32'h0, 2, 1);
        do_op(LD, 32'h2002, 32'h0, 4'b0100, 4'd5, 1'b1, 1'b0, 32'h10, 32'hAABBCCDD, 0, 3);
        chk("byte_load", ReadDataW, 32'h000000BB);
        do_op(LD, 32'h2006, 32'h0, 4'b1100, 4'd6, 1'b1, 1'b0, 32'h14, 32'h87654321, 0, 1);
        chk("half_load", ReadDataW, 32'h00008765);
        do_op(LD, 32'h3000, 32'h0, 4'b1111, 4'd7, 1'b1, 1'b0, 32'h18, 32'h13579BDF, 0, 2);
        do_op(ST, 32'h3004, 32'h2468ACE0, 4'b0011, 4'd0, 1'b0, 1'b0, 32'h1C, 32'h0, 0, 1);

        do_op(NOP, 32'h5555, 32'h0, 4'b0000, 4'd7, 1'b1, 1'b1, 32'h44, 32'h0, 0, 1);
        ALUResultM = 32'h4000; MemtoRegM = 1; beM = 4'b1111; RegWriteM = 1; dbus_ready = 1;
        @(posedge clk);
        #1;
        dbus_ready = 0;
        @(negedge clk);
        chk("wait_rd_stall", 32'(stallM), 32'd1);
        reset_n = 0;
        set_nop();
        #1;
        chk("midrst_ALUOutW", ALUOutW, 32'd0);
        chk("midrst_PCPlus4W", PCPlus4W, 32'd0);
        chk("midrst_WA3W", 32'(WA3W), 32'd0);
        chk("midrst_stallM", 32'(stallM), 32'd0);
        chk("midrst_dbus_valid", 32'(dbus_valid), 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        dbus_rdata = 32'hDEADBEEF;
        dbus_rvalid = 1;
        @(posedge clk);
        #1;
        dbus_rvalid = 0;
        chk("late_rvalid_data", ReadDataW, 32'd0);
        chk("late_rvalid_m2r", 32'(MemtoRegW), 32'd0);
        do_op(ST, 32'h5008, 32'h0BADF00D, 4'b1111, 4'd0, 1'b0, 1'b0, 32'h48, 32'h0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 2));
            rw = (kind == LD) ? 1'b1 : (kind == ST) ? 1'b0 : 1'($urandom_range(0, 1));
            do_op(kind, $urandom, $urandom, legal_be[$urandom_range(0, 6)], 4'($urandom),
                  rw, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
